// File: rtl/pp_pipeline_accel_fifo_rd_axis_if.sv
// FIFO read port and AXI4-Stream master bundle for pp_pipeline_accel_fifo_rd_axis.
// m_axis_tuser exists only when PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN is defined.
interface pp_pipeline_accel_fifo_rd_axis_if #(
    parameter int unsigned DATA_WIDTH = 64
) ();
    logic                  if_empty_n;
    logic                  if_read;
    logic [DATA_WIDTH-1:0] if_dout;
    logic                  m_axis_tvalid;
    logic                  m_axis_tready;
    logic [DATA_WIDTH-1:0] m_axis_tdata;
    logic                  m_axis_tlast;
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
    logic                  m_axis_tuser;

    modport master (
        input  if_empty_n, if_dout, m_axis_tready,
        output if_read, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );
    modport slave (
        output if_empty_n, if_dout, m_axis_tready,
        input  if_read, m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser
    );
`else
    modport master (
        input  if_empty_n, if_dout, m_axis_tready,
        output if_read, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
    modport slave (
        output if_empty_n, if_dout, m_axis_tready,
        input  if_read, m_axis_tvalid, m_axis_tdata, m_axis_tlast
    );
`endif
endinterface

// File: rtl/pp_pipeline_accel_fifo_rd_axis.sv
// Reads pkt_len words from a show-ahead FIFO and emits them as one AXI4-Stream packet
// through a 2-entry skid buffer. Optional SOF tuser: PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN.
module pp_pipeline_accel_fifo_rd_axis #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] pkt_len,
    output logic                 busy,
    output logic                 done,
    pp_pipeline_accel_fifo_rd_axis_if.master bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;
    logic [LEN_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [LEN_WIDTH-1:0]  beat_cnt_q, beat_cnt_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;

    // Output entry drives the stream; skid entry catches a pop made while the output stalls.
    logic                  out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                  out_last_q, out_last_d;
    logic                  skid_valid_q, skid_valid_d;
    logic [DATA_WIDTH-1:0] skid_data_q, skid_data_d;
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
    logic                  out_user_q, out_user_d;
`endif

    logic                  hs_c;
    logic                  if_read_c;
    logic                  pop_c;
    logic                  load_c;

    always_comb begin
        hs_c      = out_valid_q && bus.m_axis_tready;
        // Skid occupied implies output occupied, so a draining output frees a slot.
        if_read_c = !reset && (state_q == S_RUN) && (rd_cnt_q < len_q)
                    && (!skid_valid_q || bus.m_axis_tready);
        pop_c     = if_read_c && bus.if_empty_n;

        state_d      = state_q;
        len_d        = len_q;
        rd_cnt_d     = pop_c ? rd_cnt_q + LEN_WIDTH'(1) : rd_cnt_q;
        beat_cnt_d   = hs_c ? beat_cnt_q + LEN_WIDTH'(1) : beat_cnt_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_last_d   = out_last_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
        out_user_d   = out_user_q;
`endif
        load_c       = 1'b0;

        // Skid buffer movement
        if (hs_c || !out_valid_q) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_data_d   = skid_data_q;
                skid_valid_d = pop_c;
                if (pop_c) begin
                    skid_data_d = bus.if_dout;
                end
                load_c = 1'b1;
            end else begin
                out_valid_d = pop_c;
                if (pop_c) begin
                    out_data_d = bus.if_dout;
                end
                load_c = pop_c;
            end
        end else if (pop_c) begin
            skid_valid_d = 1'b1;
            skid_data_d  = bus.if_dout;
        end

        // Sideband flags follow the beat index of the word entering the output entry.
        if (load_c) begin
            out_last_d = (beat_cnt_d == len_q - LEN_WIDTH'(1));
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
            out_user_d = (beat_cnt_d == '0);
`endif
        end else if (!out_valid_d) begin
            out_last_d = 1'b0;
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
            out_user_d = 1'b0;
`endif
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d      = pkt_len;
                    rd_cnt_d   = '0;
                    beat_cnt_d = '0;
                    state_d    = (pkt_len != '0) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                if (hs_c && out_last_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            rd_cnt_q     <= '0;
            beat_cnt_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_last_q   <= 1'b0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
            out_user_q   <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            rd_cnt_q     <= rd_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_last_q   <= out_last_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
            out_user_q   <= out_user_d;
`endif
        end
    end

    assign busy              = busy_q;
    assign done              = done_q;
    assign bus.if_read       = if_read_c;
    assign bus.m_axis_tvalid = out_valid_q;
    assign bus.m_axis_tdata  = out_data_q;
    assign bus.m_axis_tlast  = out_last_q;
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
    assign bus.m_axis_tuser  = out_user_q;
`endif

endmodule

// File: tb/tb_pp_pipeline_accel_fifo_rd_axis.sv
// Randomized bench for pp_pipeline_accel_fifo_rd_axis: a FIFO queue feeds the DUT and every
// cycle is checked against a packet-level model (packet k carries the next pkt_len FIFO words).
module tb_pp_pipeline_accel_fifo_rd_axis;
    localparam int unsigned DW = 64;
    localparam int unsigned LW = 5;
    localparam int MAXLEN = (1 << LW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [LW-1:0] pkt_len = '0;
    logic          busy;
    logic          done;

    pp_pipeline_accel_fifo_rd_axis_if #(.DATA_WIDTH(DW)) bus ();

    pp_pipeline_accel_fifo_rd_axis #(.DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .pkt_len (pkt_len),
        .busy    (busy),
        .done    (done),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    logic [DW-1:0] fifo_q[$];
    logic [DW-1:0] hist_q[$];
    int  base = 0;
    int  plen = 0;
    int  popped = 0;
    int  beats = 0;
    bit  run_m = 1'b0;
    bit  done_m = 1'b0;
    int  rmode = 0;
    int  push_pct = 0;
    bit  tog = 1'b0;

    task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic push_word();
        logic [DW-1:0] w;
        w = {$urandom, $urandom};
        fifo_q.push_back(w);
        hist_q.push_back(w);
    endtask

    // One clock cycle: drive inputs, check outputs against the model, advance the model.
    task automatic step(input bit st, input int len);
        bit hs;
        bit pop;
        bit exp_rd;
        int infl;
        @(negedge clk);
        if (fifo_q.size() < 64 && $urandom_range(99) < push_pct) push_word();
        start   = st;
        pkt_len = LW'(len);
        bus.m_axis_tready = (rmode == 0) ? 1'b1 : (rmode == 1) ? tog : 1'($urandom_range(1));
        tog = ~tog;
        bus.if_empty_n = (fifo_q.size() != 0);
        bus.if_dout    = (fifo_q.size() != 0) ? fifo_q[0] : {$urandom, $urandom};
        #1;
        infl = popped - beats;
        check("busy", 64'(busy), 64'(run_m || done_m));
        check("done", 64'(done), 64'(done_m));
        check("tvalid", 64'(bus.m_axis_tvalid), 64'(infl > 0));
        exp_rd = run_m && (popped < plen) && (infl < 2 || bus.m_axis_tready);
        check("if_read", 64'(bus.if_read), 64'(exp_rd));
        if (bus.m_axis_tvalid && (base + beats) < hist_q.size()) begin
            check("tdata", bus.m_axis_tdata, hist_q[base + beats]);
            check("tlast", 64'(bus.m_axis_tlast), 64'(beats == plen - 1));
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
            check("tuser", 64'(bus.m_axis_tuser), 64'(beats == 0));
`endif
        end
        hs  = bus.m_axis_tvalid && bus.m_axis_tready;
        pop = bus.if_read && bus.if_empty_n;
        if (pop) begin
            void'(fifo_q.pop_front());
            popped++;
        end
        if (done_m) begin
            done_m = 1'b0;
        end else if (run_m) begin
            if (hs) begin
                beats++;
                if (beats == plen) begin
                    run_m  = 1'b0;
                    done_m = 1'b1;
                    base  += plen;
                    check("pops_per_pkt", 64'(popped), 64'(plen));
                end
            end
        end else if (st) begin
            plen   = len;
            popped = 0;
            beats  = 0;
            if (len > 0) run_m = 1'b1;
            else         done_m = 1'b1;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        start = 1'b0;
        bus.m_axis_tready = 1'b0;
        #1;
        check("rst_if_read_now", 64'(bus.if_read), 64'd0);
        @(negedge clk);
        #1;
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_if_read", 64'(bus.if_read), 64'd0);
        check("rst_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("rst_tlast", 64'(bus.m_axis_tlast), 64'd0);
        check("rst_tdata", bus.m_axis_tdata, 64'd0);
`ifdef PP_PIPELINE_ACCEL_FIFO_RD_AXIS_TUSER_SOF_EN
        check("rst_tuser", 64'(bus.m_axis_tuser), 64'd0);
`endif
        reset  = 1'b0;
        base  += popped;
        run_m  = 1'b0;
        done_m = 1'b0;
        popped = 0;
        beats  = 0;
    endtask

    // Runs one packet; abort >= 0 resets the DUT once that many beats have been taken.
    task automatic run_pkt(input int len, input int rm, input int pp, input int preload,
                           input int abort, output int cycles);
        int rl;
        rmode    = rm;
        push_pct = pp;
        tog      = 1'b1;
        cycles   = 0;
        for (int i = 0; i < preload; i++) push_word();
        step(1'b1, len);
        for (int c = 0; c < 3000 && (run_m || done_m); c++) begin
            if (abort >= 0 && beats == abort && run_m) begin
                do_reset();
                return;
            end
            rl = $urandom_range(MAXLEN);
            step(($urandom_range(7) == 0), rl);
            cycles++;
        end
        if (run_m || done_m) check("timeout", 64'd1, 64'd0);
    endtask

    int cyc;

    initial begin
        bus.if_empty_n    = 1'b0;
        bus.if_dout       = '0;
        bus.m_axis_tready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("init_busy", 64'(busy), 64'd0);
        check("init_done", 64'(done), 64'd0);
        check("init_tvalid", 64'(bus.m_axis_tvalid), 64'd0);
        check("init_tdata", bus.m_axis_tdata, 64'd0);
        check("init_if_read", 64'(bus.if_read), 64'd0);
        reset = 1'b0;

        // Four preloaded words at full rate: start, 4 pops, 4 beats, done.
        run_pkt(4, 0, 0, 4, -1, cyc);
        check("len4_cycles", 64'(cyc), 64'd6);

        // Surplus words stay in the FIFO.
        run_pkt(8, 0, 0, 12, -1, cyc);
        check("len8_left", 64'(fifo_q.size()), 64'd4);

        // Alternating tready; leftover 4 words plus 2 more.
        run_pkt(6, 1, 0, 2, -1, cyc);
        check("len6_left", 64'(fifo_q.size()), 64'd0);

        run_pkt(0, 0, 0, 2, -1, cyc);
        check("len0_no_pop", 64'(fifo_q.size()), 64'd2);
        run_pkt(1, 0, 0, 0, -1, cyc);
        run_pkt(1, 2, 0, 0, -1, cyc);

        // Mid-packet reset, then a clean packet.
        run_pkt(5, 0, 0, 5, 2, cyc);
        run_pkt(3, 0, 0, 3, -1, cyc);

        // Back-to-back short packets.
        run_pkt(3, 0, 0, 6, -1, cyc);
        run_pkt(3, 0, 0, 0, -1, cyc);

        // Maximum length with a starving FIFO and random backpressure.
        run_pkt(MAXLEN, 2, 50, 0, -1, cyc);
        run_pkt(MAXLEN, 0, 100, 0, -1, cyc);

        for (int k = 0; k < 30; k++) begin
            run_pkt($urandom_range(MAXLEN), $urandom_range(2), $urandom_range(20, 100),
                    $urandom_range(8), ($urandom_range(9) == 0) ? 1 : -1, cyc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
